// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline stall/flush controller with registered mispredict redirect handshake
module pipe_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        stallreq_if,
  input  logic        stallreq_id,
  input  logic        stallreq_mem,
  input  logic        br,
  input  logic [31:0] ex_jmp_addr,
  input  logic        redirect_ready,
  output logic [5:0]  stall,
  output logic        flush_if,
  output logic        redirect_valid,
  output logic [31:0] redirect_addr,
  output logic [31:0] stall_cycles,
  output logic [15:0] flush_count
);
  typedef enum logic [1:0] {RUN, REDIRECT, DRAIN} state_t;
  state_t      state_q, state_d;
  logic        redirect_valid_q, redirect_valid_d;
  logic [31:0] redirect_addr_q, redirect_addr_d;
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [15:0] flush_count_q, flush_count_d;
  logic        accept;
  // stall priority, flush and next-state; everything freezes while rdy is low
  always_comb begin
    state_d          = state_q;
    redirect_valid_d = redirect_valid_q;
    redirect_addr_d  = redirect_addr_q;
    flush_count_d    = flush_count_q;
    accept = rst && rdy && state_q == RUN && br && !stallreq_mem;
    stall  = (!rst || !rdy) ? 6'b111111 :
             stallreq_mem   ? 6'b011111 :
             stallreq_id    ? 6'b000111 :
             (state_q == REDIRECT || stallreq_if) ? 6'b000011 : 6'b000000;
    flush_if = accept || (rst && state_q == DRAIN);
    stall_cycles_d = (rdy && stall != 6'b0 && stall_cycles_q != 32'hFFFFFFFF) ?
                     stall_cycles_q + 32'd1 : stall_cycles_q;
    if (rdy) begin
      case (state_q)
        RUN: if (accept) begin
          state_d          = REDIRECT;
          redirect_valid_d = 1'b1;
          redirect_addr_d  = ex_jmp_addr;
          flush_count_d    = flush_count_q + 16'd1;
        end
        REDIRECT: if (redirect_ready) begin
          state_d          = DRAIN;
          redirect_valid_d = 1'b0;
        end
        default: state_d = RUN;
      endcase
    end
  end
  // state and counter registers, cleared asynchronously by reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q          <= RUN;
      redirect_valid_q <= 1'b0;
      redirect_addr_q  <= 32'h0;
      stall_cycles_q   <= 32'h0;
      flush_count_q    <= 16'h0;
    end else begin
      state_q          <= state_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_addr_q  <= redirect_addr_d;
      stall_cycles_q   <= stall_cycles_d;
      flush_count_q    <= flush_count_d;
    end
  end
  assign redirect_valid = redirect_valid_q;
  assign redirect_addr  = redirect_addr_q;
  assign stall_cycles   = stall_cycles_q;
  assign flush_count    = flush_count_q;
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed-vector scoreboard bench for pipe_ctrl
module tb_pipe_ctrl;
  logic        clk = 1'b0;
  logic        rst, rdy, stallreq_if, stallreq_id, stallreq_mem, br, redirect_ready;
  logic [31:0] ex_jmp_addr;
  logic [5:0]  stall;
  logic        flush_if, redirect_valid;
  logic [31:0] redirect_addr, stall_cycles;
  logic [15:0] flush_count;
  typedef struct packed {
    logic [5:0]  st;
    logic        fl;
    logic        rv;
    logic [31:0] ra;
    logic [31:0] sc;
    logic [15:0] fc;
  } exp_t;
  exp_t q[$];
  exp_t mon_e;
  int n_tests = 0;
  int n_fail  = 0;
  pipe_ctrl dut (
    .clk(clk), .rst(rst), .rdy(rdy), .stallreq_if(stallreq_if), .stallreq_id(stallreq_id),
    .stallreq_mem(stallreq_mem), .br(br), .ex_jmp_addr(ex_jmp_addr), .redirect_ready(redirect_ready),
    .stall(stall), .flush_if(flush_if), .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic step(input logic r, sif, sid, smem, b, input logic [31:0] a, input logic rr,
                      input logic [5:0] est, input logic efl, erv, input logic [31:0] era, esc,
                      input logic [15:0] efc);
    @(posedge clk);
    #1;
    rdy = r; stallreq_if = sif; stallreq_id = sid; stallreq_mem = smem;
    br = b; ex_jmp_addr = a; redirect_ready = rr;
    q.push_back('{est, efl, erv, era, esc, efc});
  endtask
  always @(negedge clk) begin
    if (q.size() != 0) begin
      mon_e = q.pop_front();
      chk("stall", {26'b0, stall}, {26'b0, mon_e.st});
      chk("flush_if", {31'b0, flush_if}, {31'b0, mon_e.fl});
      chk("redirect_valid", {31'b0, redirect_valid}, {31'b0, mon_e.rv});
      chk("redirect_addr", redirect_addr, mon_e.ra);
      chk("stall_cycles", stall_cycles, mon_e.sc);
      chk("flush_count", {16'b0, flush_count}, {16'b0, mon_e.fc});
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end
  initial begin
    rst = 1'b0; rdy = 1'b1; stallreq_if = 1'b0; stallreq_id = 1'b0; stallreq_mem = 1'b0;
    br = 1'b0; ex_jmp_addr = 32'h0; redirect_ready = 1'b0;
    #2;
    chk("reset_stall_async", {26'b0, stall}, 32'h3F);
    chk("reset_flush_async", {31'b0, flush_if}, 32'h0);
    step(1,0,0,0,0,32'h0,0, 6'h3F,0,0,32'h0,32'd0,16'd0);
    @(negedge clk); #1 rst = 1'b1;
    // load-use stall
    step(1,0,1,0,0,32'h0,0, 6'h07,0,0,32'h0,32'd0,16'd0);
    step(1,0,1,0,0,32'h0,0, 6'h07,0,0,32'h0,32'd1,16'd0);
    step(1,0,0,0,0,32'h0,0, 6'h00,0,0,32'h0,32'd2,16'd0);
    // mispredict with delayed acceptance; second br during REDIRECT ignored
    step(1,0,0,0,1,32'h1040,0, 6'h00,1,0,32'h0,32'd2,16'd0);
    step(1,0,0,0,0,32'h0,0,    6'h03,0,1,32'h1040,32'd2,16'd1);
    step(1,0,0,0,0,32'h0,0,    6'h03,0,1,32'h1040,32'd3,16'd1);
    step(1,0,0,0,1,32'h2000,0, 6'h03,0,1,32'h1040,32'd4,16'd1);
    step(1,0,0,0,0,32'h0,1,    6'h03,0,1,32'h1040,32'd5,16'd1);
    step(1,0,0,0,0,32'h0,0,    6'h00,1,0,32'h1040,32'd6,16'd1);
    step(1,0,0,0,0,32'h0,0,    6'h00,0,0,32'h1040,32'd6,16'd1);
    // br under memory stall; ready high in acceptance cycle is not a handshake
    step(1,0,0,1,1,32'h3000,1, 6'h1F,0,0,32'h1040,32'd6,16'd1);
    step(1,0,0,1,1,32'h3000,1, 6'h1F,0,0,32'h1040,32'd7,16'd1);
    step(1,0,0,0,1,32'h3000,1, 6'h00,1,0,32'h1040,32'd8,16'd1);
    step(1,0,0,0,0,32'h0,0,    6'h03,0,1,32'h3000,32'd8,16'd2);
    // rdy low during REDIRECT freezes everything
    step(0,0,0,0,0,32'h0,1,    6'h3F,0,1,32'h3000,32'd9,16'd2);
    step(0,0,0,0,0,32'h0,1,    6'h3F,0,1,32'h3000,32'd9,16'd2);
    step(1,0,0,0,0,32'h0,1,    6'h03,0,1,32'h3000,32'd9,16'd2);
    step(1,0,0,0,0,32'h0,0,    6'h00,1,0,32'h3000,32'd10,16'd2);
    // request priority
    step(1,1,0,0,0,32'h0,0,    6'h03,0,0,32'h3000,32'd10,16'd2);
    step(1,1,1,0,0,32'h0,0,    6'h07,0,0,32'h3000,32'd11,16'd2);
    step(1,1,1,1,0,32'h0,0,    6'h1F,0,0,32'h3000,32'd12,16'd2);
    step(1,0,0,0,0,32'h0,0,    6'h00,0,0,32'h3000,32'd13,16'd2);
    // rdy low blocks br acceptance in RUN
    step(0,0,0,0,1,32'h4000,0, 6'h3F,0,0,32'h3000,32'd13,16'd2);
    step(1,0,0,0,0,32'h0,0,    6'h00,0,0,32'h3000,32'd13,16'd2);
    // reset mid-redirect
    step(1,0,0,0,1,32'h5000,0, 6'h00,1,0,32'h3000,32'd13,16'd2);
    step(1,0,0,0,0,32'h0,0,    6'h03,0,1,32'h5000,32'd13,16'd3);
    @(negedge clk); #2 rst = 1'b0;
    #1;
    chk("midreset_rv", {31'b0, redirect_valid}, 32'h0);
    chk("midreset_addr", redirect_addr, 32'h0);
    chk("midreset_sc", stall_cycles, 32'h0);
    chk("midreset_fc", {16'b0, flush_count}, 32'h0);
    chk("midreset_stall", {26'b0, stall}, 32'h3F);
    step(1,0,0,0,0,32'h0,1,    6'h3F,0,0,32'h0,32'd0,16'd0);
    @(negedge clk); #1 rst = 1'b1;
    step(1,0,0,0,0,32'h0,0,    6'h00,0,0,32'h0,32'd0,16'd0);
    // stall_cycles saturation
    @(negedge clk); #2 force dut.stall_cycles_q = 32'hFFFFFFFD;
    #1 release dut.stall_cycles_q;
    step(1,1,0,0,0,32'h0,0,    6'h03,0,0,32'h0,32'hFFFFFFFD,16'd0);
    step(1,1,0,0,0,32'h0,0,    6'h03,0,0,32'h0,32'hFFFFFFFE,16'd0);
    step(1,1,0,0,0,32'h0,0,    6'h03,0,0,32'h0,32'hFFFFFFFF,16'd0);
    step(1,1,0,0,0,32'h0,0,    6'h03,0,0,32'h0,32'hFFFFFFFF,16'd0);
    step(1,0,0,0,0,32'h0,0,    6'h00,0,0,32'h0,32'hFFFFFFFF,16'd0);
    // flush_count wrap
    @(negedge clk); #2 force dut.flush_count_q = 16'hFFFF;
    #1 release dut.flush_count_q;
    step(1,0,0,0,1,32'h6000,0, 6'h00,1,0,32'h0,32'hFFFFFFFF,16'hFFFF);
    step(1,0,0,0,0,32'h0,1,    6'h03,0,1,32'h6000,32'hFFFFFFFF,16'h0000);
    step(1,0,0,0,0,32'h0,0,    6'h00,1,0,32'h6000,32'hFFFFFFFF,16'h0000);
    step(1,0,0,0,0,32'h0,0,    6'h00,0,0,32'h6000,32'hFFFFFFFF,16'h0000);
    @(negedge clk);
    @(negedge clk);
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
